// File: rtl/io_responder_pkg.sv
// Shared constants and types for the IO responder: address map, write
// response codes, the default read value and the UART serializer states.
package io_responder_pkg;

    localparam logic [31:0] ADDR_TEST      = 32'h8000_0000;
    localparam logic [31:0] ADDR_UART_TX   = 32'h8000_0004;
    localparam logic [31:0] ADDR_TIMER     = 32'h8000_0008;
    localparam logic [31:0] ADDR_UART_STAT = 32'h8000_000C;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    localparam logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // UART status word: level in [7:0], busy in bit 8, full in bit 9.
    function automatic logic [31:0] uart_stat_word(input logic [7:0] level,
                                                   input logic       busy,
                                                   input logic       full);
        return {22'd0, full, busy, level};
    endfunction

endpackage

// File: rtl/io_uart_tx.sv
// 8N1 UART serializer. Accepts one byte through a valid/ready handshake and
// shifts it out LSB first. A new byte may be accepted in the last cycle of
// the stop bit so consecutive frames are emitted without an idle gap.
module io_uart_tx
    import io_responder_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       txd,
    output logic       busy
);

    localparam int              BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0]   BAUD_ZERO = {BW{1'b0}};

    uart_state_e   state_r;
    uart_state_e   state_s;
    logic [BW-1:0] baud_r;
    logic [BW-1:0] baud_s;
    logic [2:0]    bit_r;
    logic [2:0]    bit_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_s;
    logic          txd_r;
    logic          txd_s;
    logic          busy_r;
    logic          busy_s;
    logic          baud_last_s;

    // Next-state, counters and the line level that the next state will drive.
    always_comb begin
        state_s     = state_r;
        baud_s      = baud_r;
        bit_s       = bit_r;
        shift_s     = shift_r;
        baud_last_s = (baud_r == BAUD_LAST);
        in_ready    = 1'b0;
        case (state_r)
            UART_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_s = UART_START;
                    baud_s  = BAUD_ZERO;
                    shift_s = in_data;
                end else begin
                    state_s = UART_IDLE;
                end
            end
            UART_START: begin
                if (baud_last_s) begin
                    state_s = UART_DATA;
                    baud_s  = BAUD_ZERO;
                    bit_s   = 3'd0;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            UART_DATA: begin
                if (baud_last_s) begin
                    baud_s  = BAUD_ZERO;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = UART_STOP;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                    end
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            UART_STOP: begin
                in_ready = baud_last_s;
                if (baud_last_s) begin
                    baud_s = BAUD_ZERO;
                    if (in_valid) begin
                        state_s = UART_START;
                        shift_s = in_data;
                    end else begin
                        state_s = UART_IDLE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = UART_IDLE;
                baud_s  = BAUD_ZERO;
                bit_s   = 3'd0;
            end
        endcase

        case (state_s)
            UART_START: txd_s = 1'b0;
            UART_DATA:  txd_s = shift_s[0];
            default:    txd_s = 1'b1;
        endcase
        busy_s = (state_s != UART_IDLE);
    end

    // Serializer state and registered line/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= UART_IDLE;
            baud_r  <= BAUD_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            txd_r   <= txd_s;
            busy_r  <= busy_s;
        end
    end

    assign txd  = txd_r;
    assign busy = busy_r;

endmodule

// File: rtl/io_responder.sv
// Data-bus responder for the IO window: TEST register, UART transmit FIFO
// feeding an 8N1 serializer, a free-running timer and a UART status word.
// Read and write channels each allow a single outstanding transaction.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int RESP_WIDTH = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dr_addr_valid,
    output logic                  dr_addr_ready,
    input  logic [BUS_WIDTH-1:0]  dr_addr,
    output logic                  dr_data_valid,
    input  logic                  dr_data_ready,
    output logic [BUS_WIDTH-1:0]  dr_data,
    input  logic                  dw_data_addr_valid,
    output logic                  dw_data_addr_ready,
    input  logic [BUS_WIDTH-1:0]  dw_addr,
    input  logic [BUS_WIDTH-1:0]  dw_data,
    input  logic [3:0]            dw_strobe,
    output logic                  dw_resp_valid,
    input  logic                  dw_resp_ready,
    output logic [RESP_WIDTH-1:0] dw_resp,
    output logic                  uart_txd,
    output logic                  test_done,
    output logic [BUS_WIDTH-1:0]  test_code
);

    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [7:0]            fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           level_r;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  uart_ready_s;
    logic                  uart_busy_s;

    logic                  rd_pending_r;
    logic [BUS_WIDTH-1:0]  rd_data_r;
    logic [BUS_WIDTH-1:0]  rd_capture_s;
    logic                  rd_hs_s;
    logic                  rd_done_s;

    logic                  wr_pending_r;
    logic [RESP_WIDTH-1:0] resp_r;
    logic                  wr_hs_s;
    logic                  wr_done_s;
    logic                  test_ok_s;
    logic                  uart_ok_s;
    logic                  test_done_r;
    logic [BUS_WIDTH-1:0]  test_code_r;
    logic [31:0]           timer_r;

    assign fifo_full_s  = (level_r == LVL_FULL);
    assign fifo_empty_s = (level_r == {(AW+1){1'b0}});

    assign dr_addr_ready      = !rst && !rd_pending_r;
    assign dw_data_addr_ready = !rst && !wr_pending_r &&
                                !((dw_addr == ADDR_UART_TX) && fifo_full_s);

    assign rd_hs_s   = dr_addr_valid && dr_addr_ready;
    assign rd_done_s = rd_pending_r && dr_data_ready;
    assign wr_hs_s   = dw_data_addr_valid && dw_data_addr_ready;
    assign wr_done_s = wr_pending_r && dw_resp_ready;

    assign test_ok_s = (dw_addr == ADDR_TEST) && (dw_strobe == 4'hF);
    assign uart_ok_s = (dw_addr == ADDR_UART_TX) && dw_strobe[0];
    assign push_s    = wr_hs_s && uart_ok_s;
    assign pop_s     = uart_ready_s && !fifo_empty_s;

    // Read data selection for the value captured at the address handshake.
    always_comb begin
        rd_capture_s = RD_DEFAULT;
        if (dr_addr == ADDR_TIMER) begin
            rd_capture_s = timer_r;
        end else if (dr_addr == ADDR_UART_STAT) begin
            rd_capture_s = uart_stat_word(8'(level_r), uart_busy_s, fifo_full_s);
        end else begin
            rd_capture_s = RD_DEFAULT;
        end
    end

    // Read channel: capture on address handshake, hold until data accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending_r <= 1'b0;
            rd_data_r    <= {BUS_WIDTH{1'b0}};
        end else if (rd_hs_s) begin
            rd_pending_r <= 1'b1;
            rd_data_r    <= rd_capture_s;
        end else if (rd_done_s) begin
            rd_pending_r <= 1'b0;
        end
    end

    // Write channel: response code and TEST register side effects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pending_r <= 1'b0;
            resp_r       <= {RESP_WIDTH{1'b0}};
            test_done_r  <= 1'b0;
            test_code_r  <= {BUS_WIDTH{1'b0}};
        end else begin
            test_done_r <= wr_hs_s && test_ok_s;
            if (wr_hs_s && test_ok_s) begin
                test_code_r <= dw_data;
            end
            if (wr_hs_s) begin
                wr_pending_r <= 1'b1;
                resp_r       <= (test_ok_s || uart_ok_s) ? RESP_WIDTH'(RESP_OK)
                                                         : RESP_WIDTH'(RESP_ERR);
            end else if (wr_done_s) begin
                wr_pending_r <= 1'b0;
            end
        end
    end

    // Free-running timer, wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r <= 32'd0;
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= dw_data[7:0];
        end
    end

    // FIFO pointers and level; full-FIFO pushes are already blocked by ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    io_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk      (clk),
        .rst      (rst),
        .in_valid (!fifo_empty_s),
        .in_ready (uart_ready_s),
        .in_data  (fifo_mem_r[rd_ptr_r]),
        .txd      (uart_txd),
        .busy     (uart_busy_s)
    );

    assign dr_data_valid = rd_pending_r;
    assign dr_data       = rd_data_r;
    assign dw_resp_valid = wr_pending_r;
    assign dw_resp       = resp_r;
    assign test_done     = test_done_r;
    assign test_code     = test_code_r;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with BAUD_DIV=4 and an 8-entry FIFO.
module tb_io_responder;
    import io_responder_pkg::*;

    localparam int BAUD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dr_addr_valid = 1'b0;
    logic        dr_addr_ready;
    logic [31:0] dr_addr = 32'd0;
    logic        dr_data_valid;
    logic        dr_data_ready = 1'b1;
    logic [31:0] dr_data;
    logic        dw_data_addr_valid = 1'b0;
    logic        dw_data_addr_ready;
    logic [31:0] dw_addr = 32'd0;
    logic [31:0] dw_data = 32'd0;
    logic [3:0]  dw_strobe = 4'd0;
    logic        dw_resp_valid;
    logic        dw_resp_ready = 1'b1;
    logic [0:0]  dw_resp;
    logic        uart_txd;
    logic        test_done;
    logic [31:0] test_code;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    io_responder #(
        .BUS_WIDTH  (32),
        .RESP_WIDTH (1),
        .FIFO_DEPTH (8),
        .BAUD_DIV   (BAUD)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .dr_addr_valid      (dr_addr_valid),
        .dr_addr_ready      (dr_addr_ready),
        .dr_addr            (dr_addr),
        .dr_data_valid      (dr_data_valid),
        .dr_data_ready      (dr_data_ready),
        .dr_data            (dr_data),
        .dw_data_addr_valid (dw_data_addr_valid),
        .dw_data_addr_ready (dw_data_addr_ready),
        .dw_addr            (dw_addr),
        .dw_data            (dw_data),
        .dw_strobe          (dw_strobe),
        .dw_resp_valid      (dw_resp_valid),
        .dw_resp_ready      (dw_resp_ready),
        .dw_resp            (dw_resp),
        .uart_txd           (uart_txd),
        .test_done          (test_done),
        .test_code          (test_code)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Cycle counter used to time frame starts.
    always @(posedge clk) cyc <= cyc + 1;

    // Safety net so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single read; entered and left at a negedge, dr_data_ready held high.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        int w;
        dr_data_ready = 1'b1;
        dr_addr       = addr;
        dr_addr_valid = 1'b1;
        w = 0;
        while (!dr_addr_ready && w < 100) begin @(negedge clk); w++; end
        if (!dr_addr_ready) check_eq("rd_addr_timeout", 64'(dr_addr_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        dr_addr_valid = 1'b0;
        w = 0;
        while (!dr_data_valid && w < 100) begin @(negedge clk); w++; end
        if (!dr_data_valid) check_eq("rd_data_timeout", 64'(dr_data_valid), 64'd1);
        data = dr_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single write; td is test_done sampled the cycle after the request edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic resp, output logic td);
        int w;
        dw_resp_ready      = 1'b1;
        dw_addr            = addr;
        dw_data            = data;
        dw_strobe          = strb;
        dw_data_addr_valid = 1'b1;
        w = 0;
        while (!dw_data_addr_ready && w < 200) begin @(negedge clk); w++; end
        if (!dw_data_addr_ready) check_eq("wr_req_timeout", 64'(dw_data_addr_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        dw_data_addr_valid = 1'b0;
        td = test_done;
        w = 0;
        while (!dw_resp_valid && w < 100) begin @(negedge clk); w++; end
        if (!dw_resp_valid) check_eq("wr_resp_timeout", 64'(dw_resp_valid), 64'd1);
        resp = dw_resp[0];
        @(posedge clk);
        @(negedge clk);
    endtask

    // Waits for a start bit, then records the full 10*BAUD cycle frame.
    task automatic rx_byte(input logic [7:0] exp_byte, input string tag, output int start_cyc);
        int         w;
        logic [39:0] obs;
        logic [39:0] expv;
        logic [9:0]  frame;
        w = 0;
        while (uart_txd !== 1'b0 && w < 2000) begin @(negedge clk); w++; end
        if (uart_txd !== 1'b0) check_eq({tag, "_start_timeout"}, 64'(uart_txd), 64'd0);
        start_cyc = cyc;
        frame = {1'b1, exp_byte, 1'b0};
        for (int k = 0; k < 40; k++) begin
            obs[k]  = uart_txd;
            expv[k] = frame[k / BAUD];
            @(negedge clk);
        end
        check_eq(tag, 64'(obs), 64'(expv));
    endtask

    logic [31:0] rdata;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] held;
    logic        resp;
    logic        td;
    int          s_cyc;
    int          stable;
    int          lows;
    logic [7:0]  bytes [9];
    int          starts [9];
    int          bad_resp;
    int          bad_gap;

    initial begin
        bytes = '{8'h31, 8'h32, 8'h33, 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h81, 8'h7E};

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_dr_addr_ready",      64'(dr_addr_ready),      64'd0);
        check_eq("rst_dw_data_addr_ready", 64'(dw_data_addr_ready), 64'd0);
        check_eq("rst_dr_data_valid",      64'(dr_data_valid),      64'd0);
        check_eq("rst_dw_resp_valid",      64'(dw_resp_valid),      64'd0);
        check_eq("rst_dr_data",            64'(dr_data),            64'd0);
        check_eq("rst_dw_resp",            64'(dw_resp),            64'd0);
        check_eq("rst_uart_txd",           64'(uart_txd),           64'd1);
        check_eq("rst_test_done",          64'(test_done),          64'd0);
        check_eq("rst_test_code",          64'(test_code),          64'd0);
        rst = 1'b0;

        // Timer: 20 edges after release, the 21st edge captures 20
        repeat (20) @(posedge clk);
        @(negedge clk);
        do_read(ADDR_TIMER, t1);
        check_eq("timer_first", 64'(t1), 64'd20);
        repeat (3) @(negedge clk);
        do_read(ADDR_TIMER, t2);
        check_eq("timer_second", 64'(t2), 64'd25);
        check_eq("timer_delta", 64'(t2 - t1), 64'd5);

        // TEST register
        do_write(ADDR_TEST, 32'h0100_0001, 4'hF, resp, td);
        check_eq("test_resp_ok",    64'(resp),      64'd0);
        check_eq("test_done_pulse", 64'(td),        64'd1);
        check_eq("test_done_once",  64'(test_done), 64'd0);
        check_eq("test_code",       64'(test_code), 64'h0100_0001);
        do_write(ADDR_TEST, 32'h0000_00FF, 4'h3, resp, td);
        check_eq("test_partial_resp", 64'(resp),      64'd1);
        check_eq("test_partial_done", 64'(td),        64'd0);
        check_eq("test_partial_code", 64'(test_code), 64'h0100_0001);

        // Single UART byte 'A'
        fork
            do_write(ADDR_UART_TX, 32'h0000_0041, 4'h1, resp, td);
            rx_byte(8'h41, "uart_frame_A", s_cyc);
        join
        check_eq("uart_A_resp", 64'(resp),     64'd0);
        check_eq("uart_A_idle", 64'(uart_txd), 64'd1);
        do_read(ADDR_UART_STAT, rdata);
        check_eq("uart_stat_idle", 64'(rdata), 64'd0);

        // Unmapped / read-only
        do_read(32'h8000_0010, rdata);
        check_eq("rd_unmapped", 64'(rdata), 64'hDEAD_BEEF);
        do_read(ADDR_TEST, rdata);
        check_eq("rd_write_only", 64'(rdata), 64'hDEAD_BEEF);
        do_write(ADDR_TIMER, 32'h1234_5678, 4'hF, resp, td);
        check_eq("wr_read_only_resp", 64'(resp), 64'd1);
        check_eq("wr_read_only_code", 64'(test_code), 64'h0100_0001);

        // Nine bytes back to back
        bad_resp = 0;
        bad_gap  = 0;
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    do_write(ADDR_UART_TX, {24'd0, bytes[i]}, 4'h1, resp, td);
                    if (resp !== 1'b0) bad_resp++;
                end
                check_eq("b2b_resp", 64'(bad_resp), 64'd0);
                dw_addr = ADDR_UART_TX;
                #1;
                check_eq("full_ready_low", 64'(dw_data_addr_ready), 64'd0);
                do_read(ADDR_UART_STAT, rdata);
                check_eq("full_stat", 64'(rdata), 64'h0000_0308);
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    rx_byte(bytes[i], "b2b_frame", starts[i]);
                end
                for (int i = 1; i < 9; i++) begin
                    if (starts[i] - starts[i-1] != 40) bad_gap++;
                end
                check_eq("b2b_gap", 64'(bad_gap), 64'd0);
            end
        join
        dw_addr = ADDR_UART_TX;
        #1;
        check_eq("ready_after_drain", 64'(dw_data_addr_ready), 64'd1);
        @(negedge clk);

        // Read data stall with a new request waiting
        dr_data_ready = 1'b0;
        dr_addr       = ADDR_TIMER;
        dr_addr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dr_addr = 32'h8000_0010;
        held    = dr_data;
        stable  = 0;
        repeat (10) begin
            @(negedge clk);
            if (dr_data_valid === 1'b1 && dr_data === held && dr_addr_ready === 1'b0) stable++;
        end
        check_eq("stall_stable", 64'(stable), 64'd10);
        dr_data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("stall_release_valid", 64'(dr_data_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        dr_addr_valid = 1'b0;
        check_eq("stall_next_read", 64'(dr_data), 64'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);

        // Reset during a frame with both channels holding responses
        do_write(ADDR_UART_TX, 32'h0000_0055, 4'h1, resp, td);
        do_write(ADDR_UART_TX, 32'h0000_0066, 4'h1, resp, td);
        check_eq("pre_rst_txd", 64'(uart_txd), 64'd0);
        dr_data_ready      = 1'b0;
        dw_resp_ready      = 1'b0;
        dr_addr            = ADDR_TIMER;
        dr_addr_valid      = 1'b1;
        dw_addr            = ADDR_TEST;
        dw_data            = 32'hCAFE_0001;
        dw_strobe          = 4'hF;
        dw_data_addr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dr_addr_valid      = 1'b0;
        dw_data_addr_valid = 1'b0;
        check_eq("pre_rst_rd_valid", 64'(dr_data_valid), 64'd1);
        check_eq("pre_rst_wr_valid", 64'(dw_resp_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_txd",           64'(uart_txd),           64'd1);
        check_eq("arst_dr_data_valid", 64'(dr_data_valid),      64'd0);
        check_eq("arst_dw_resp_valid", 64'(dw_resp_valid),      64'd0);
        check_eq("arst_dr_addr_ready", 64'(dr_addr_ready),      64'd0);
        check_eq("arst_dw_ready",      64'(dw_data_addr_ready), 64'd0);
        check_eq("arst_test_code",     64'(test_code),          64'd0);
        @(negedge clk);
        rst           = 1'b0;
        dr_data_ready = 1'b1;
        dw_resp_ready = 1'b1;
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        check_eq("post_rst_line_idle", 64'(lows), 64'd0);
        do_read(ADDR_UART_STAT, rdata);
        check_eq("post_rst_stat", 64'(rdata), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_responder.md
# io_responder

Synthesizable data-bus responder for the copperv core. It terminates the CPU's data-read (`dr_*`) and data-write (`dw_*`) channels for the IO window at 0x8000_0000 and provides four registers: a test-status register, a UART transmit register backed by a byte FIFO and 8N1 serializer, a free-running timer, and a UART status register. It is the hardware counterpart of the CPU's bus initiator and sits beside instruction/data memory behind the crossbar.

## Interface
- `BUS_WIDTH`, 32, address/data width.
- `RESP_WIDTH`, 1, write-response width.
- `FIFO_DEPTH`, 8, UART byte FIFO entries (power of two).
- `BAUD_DIV`, 16, clock cycles per UART bit (≥2).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous and active-high.
- `dr_addr_valid` in 1 / `dr_addr_ready` out 1 / `dr_addr` in 32: read address channel.
- `dr_data_valid` out 1 / `dr_data_ready` in 1 / `dr_data` out 32: read data channel.
- `dw_data_addr_valid` in 1 / `dw_data_addr_ready` out 1 / `dw_addr` in 32 / `dw_data` in 32 / `dw_strobe` in 4: write request.
- `dw_resp_valid` out 1 / `dw_resp_ready` in 1 / `dw_resp` out 1: write response.
- `uart_txd` out 1: serial output, idle high.
- `test_done` out 1: one-cycle pulse on each accepted TEST write.
- `test_code` out 32: last value written to TEST.

## Operation
- Address map (full 32-bit compare):
  - 0x8000_0000 TEST (W).
  - 0x8000_0004 UART_TX (W, byte in data[7:0]).
  - 0x8000_0008 TIMER (R).
  - 0x8000_000C UART_STAT (R): bits [7:0] FIFO level, bit 8 serializer busy, bit 9 FIFO full, all other bits 0.
- Read path: one outstanding read.
  - `dr_addr_ready = !rst && !rd_pending`.
  - On handshake, data is captured: TIMER value/UART_STAT as of that edge; any other address returns 0xDEAD_BEEF.
  - `dr_data_valid` then rises and is held, with `dr_data` stable, until `dr_data_ready`.
- Write path: one outstanding write.
  - `dw_data_addr_ready = !rst && !wr_pending && !(dw_addr==UART_TX && fifo_full)`.
  - Full-FIFO backpressure: ready stays low and no byte is dropped.
- Write responses:
  - RESP_OK (0) for a TEST write with strobe 4'hF, or a UART_TX write with strobe[0]=1.
  - Otherwise RESP_ERR (1), with no side effect. This includes reads-only and unmapped addresses.
- TEST write: updates `test_code` and pulses `test_done`.
- Timer: 32-bit, +1 every cycle, wraps 0xFFFF_FFFF→0.
- UART serializer states:
  - IDLE → START when FIFO is non-empty (pop on that edge).
  - START → DATA after `BAUD_DIV` cycles at 0.
  - DATA: 8 bits, LSB first, `BAUD_DIV` cycles each.
  - STOP: 1 for `BAUD_DIV` cycles → IDLE.
  - Back-to-back bytes need no idle gap.
- Simultaneous push and pop on a full FIFO: the push is already blocked by ready, so the level decrements. Push and pop on a non-full, non-empty FIFO keep the level unchanged.
- Reset mid-operation: an in-flight frame is aborted, `uart_txd` returns to 1 immediately, the FIFO is emptied, and pending responses are dropped.

## Timing
- Reset values:
  - Handshake outputs: `dr_addr_ready`=0, `dw_data_addr_ready`=0, `dr_data_valid`=0, `dw_resp_valid`=0.
  - Data outputs: `dr_data`=0, `dw_resp`=0.
  - Status outputs: `uart_txd`=1, `test_done`=0, `test_code`=0.
  - Internal state: timer=0, FIFO empty, serializer IDLE.
- Read latency: handshake at edge N → `dr_data_valid`=1 after N. With `dr_data_ready` high, the data handshake occurs at N+1 and a new address is accepted at N+2.
- Write latency: request at edge N → `dw_resp_valid` after N. `test_done`/`test_code` update at N. A UART byte is visible in the FIFO level after N.
- Frame duration: exactly 10×`BAUD_DIV` cycles. The start bit begins the cycle after the pop edge.
- The read and write channels are independent; both may handshake on the same edge.

## Structure
- Package `io_responder_pkg`:
  - Address constants: ADDR_TEST, ADDR_UART_TX, ADDR_TIMER, ADDR_UART_STAT.
  - Response constants: RESP_OK, RESP_ERR.
  - Read default: RD_DEFAULT=32'hDEAD_BEEF.
  - UART state enum.
- Sub-module `io_uart_tx`: baud counter, bit counter and shift register. It takes a byte through a valid/ready interface and outputs `txd` and `busy`. The FIFO and bus logic stay in `io_responder`.

## Test plan
- Reset, then read TIMER at cycle 20 after reset release → `dr_data`=20 (±the fixed capture offset checked once); a second read 5 cycles later returns a value 5 higher.
- Write 0x0100_0001 to TEST with strobe 4'hF → `dw_resp`=0, `test_done` pulses once, `test_code`=0x0100_0001. The same write with strobe 4'h3 → `dw_resp`=1 and `test_code` is unchanged.
- Write 'A' (0x41) to UART_TX with `BAUD_DIV`=4 → `uart_txd` shows 0, bits 1,0,0,0,0,0,1,0, then 1, each 4 cycles wide, 40 cycles total.
- Write 9 bytes back-to-back with `dw_resp_ready`=1:
  - `dw_data_addr_ready` drops while the FIFO is full.
  - UART_STAT bit 9 reads 1.
  - All 9 bytes appear on `uart_txd` in order with no gaps.
- Read 0x8000_0010 → `dr_data`=0xDEAD_BEEF. Write 0x8000_0008 → `dw_resp`=1.
- Hold `dr_data_ready`=0 for 10 cycles → `dr_data_valid` and `dr_data` stay stable and `dr_addr_ready` stays 0. Assert `rst` mid-frame → `uart_txd`=1 and all valids are 0 asynchronously.
